// File: rtl/mux_pkg.sv
// Shared types for the N-to-1 registered scan multiplexer: FSM state encoding
// and the mode input values.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan pointer with per-channel dwell counting and a wrap pulse
// that lines up with the first channel-0 sample after the pointer wraps.
module mux_scan_ctrl #(
    parameter int N_CH    = 8,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               adv,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   ptr,
    output logic               wrap
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [DWELL_W-1:0] dwell_cnt;
    logic               wrap_pend;

    // wrap_pend remembers that the pointer just wrapped; the pulse is issued
    // together with the next load so it coincides with the ch=0 sample.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr       <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (adv) begin
                wrap      <= wrap_pend;
                wrap_pend <= 1'b0;
                // >= so that lowering dwell mid-scan still lets the channel advance
                if (dwell_cnt >= dwell) begin
                    dwell_cnt <= '0;
                    if (ptr == LAST_CH) begin
                        ptr       <= '0;
                        wrap_pend <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-channel registered multiplexer with a valid/ready output stage; selects
// either a direct channel index or a round-robin scan pointer.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N_CH    = 8,
    parameter int W       = 1,
    parameter int SEL_W   = $clog2(N_CH),
    parameter int DWELL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                wrap,
    output logic [1:0]          dbg_state
);

    // Handshake: a sample transfers on a rising edge where out_valid && out_ready;
    // out_valid never depends combinationally on out_ready, and out_data/out_ch
    // stay frozen while out_valid && !out_ready.

    state_e            state, state_nx;
    logic              scan_clear;
    logic              load;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  ch;
    logic [W-1:0]      ch_data;

    always_comb begin
        state_nx   = state;
        scan_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    if (mode == MODE_SCAN) begin
                        state_nx   = ST_SCAN;
                        scan_clear = 1'b1;
                    end else begin
                        state_nx = ST_DIRECT;
                    end
                end
            end
            default: begin
                if (!en) state_nx = ST_IDLE;
                else     state_nx = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
            end
        endcase
    end

    assign load = (state != ST_IDLE) && en && (!out_valid || out_ready);
    assign ch   = (state == ST_SCAN) ? ptr : sel;

    // Indices at or beyond N_CH (non power-of-two channel counts) read as zero.
    always_comb begin
        ch_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch == SEL_W'(c)) ch_data = in_data[c*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                out_data  <= ch_data;
                out_ch    <= ch;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    mux_scan_ctrl #(
        .N_CH    (N_CH),
        .DWELL_W (DWELL_W),
        .SEL_W   (SEL_W)
    ) u_scan_ctrl (
        .clk   (clk),
        .rst   (rst),
        .clear (scan_clear),
        .adv   (load && (state == ST_SCAN)),
        .dwell (dwell),
        .ptr   (ptr),
        .wrap  (wrap)
    );

    assign dbg_state = state;

endmodule
